// File: rtl/nn_cfg_loader.sv
// ---------------------------------------------------------------------------
// nn_cfg_loader
//   Host-side writer for the accelerator configuration register file.
//   Parses a host byte stream into packets (header, then low/high byte pairs)
//   and issues one-cycle address/data/write-enable strobes per 16-bit word.
//
//   Optional feature (macro NN_CFG_LOADER_CHKSUM_EN): a trailing checksum
//   byte (XOR of header and payload bytes) is accepted in a CHK state; a
//   mismatch raises the sticky o_err flag together with the o_done pulse.
//   Without the macro there is no CHK state and o_err is tied low.
//
// Ports
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_byte       host byte, sampled only on accepted cycles
//   i_byte_vld   host byte valid
//   o_byte_rdy   loader can accept a byte
//   o_cfg_addr   register file write address (holds last written value)
//   o_cfg_data   register file write data (holds last written value)
//   o_cfg_wr_en  register file write strobe, one cycle per word
//   o_busy       packet in progress
//   o_done       one-cycle pulse at packet end
//   o_err        sticky checksum error, cleared by reset or next header byte
//   o_dbg_state  current FSM state encoding, for observation only
//
// Handshake: a byte transfers on every rising edge where i_byte_vld and
// o_byte_rdy are both high; o_byte_rdy depends only on the FSM state, never
// on i_byte_vld, and i_byte is ignored on any cycle without a transfer.
// ---------------------------------------------------------------------------
module nn_cfg_loader #(
    parameter int NUM_REG = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_vld,
    output logic              o_byte_rdy,
    output logic [ADDR_W-1:0] o_cfg_addr,
    output logic [DATA_W-1:0] o_cfg_data,
    output logic              o_cfg_wr_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_LAST = 3'd3,   // cycle carrying the final write strobe
        S_DONE = 3'd4,
        S_CHK  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                accept;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [3:0]          word_cnt;
    logic [7:0]          lo_byte;

    assign accept      = i_byte_vld && o_byte_rdy;
    assign o_dbg_state = state_q;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR:  if (accept) state_d = S_LO;
            S_LO:   if (accept) state_d = S_HI;
            S_HI: begin
                if (accept) begin
                    if (word_cnt == 4'd0) begin
`ifdef NN_CFG_LOADER_CHKSUM_EN
                        state_d = S_CHK;
`else
                        // Spend the strobe cycle in S_LAST so o_done
                        // lands one cycle after the final write.
                        state_d = S_LAST;
`endif
                    end else begin
                        state_d = S_LO;
                    end
                end
            end
            S_LAST: state_d = S_DONE;
`ifdef NN_CFG_LOADER_CHKSUM_EN
            S_CHK:  if (accept) state_d = S_DONE;
`endif
            S_DONE: state_d = S_HDR;
            default: state_d = S_HDR;
        endcase
    end

    // Output decode
    always_comb begin
        o_byte_rdy = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state_q)
            S_HDR:  o_byte_rdy = 1'b1;
            S_LO:   begin o_byte_rdy = 1'b1; o_busy = 1'b1; end
            S_HI:   begin o_byte_rdy = 1'b1; o_busy = 1'b1; end
            S_LAST: o_busy = 1'b1;
            S_CHK:  begin o_byte_rdy = 1'b1; o_busy = 1'b1; end
            S_DONE: o_done = 1'b1;
            default: o_byte_rdy = 1'b0;
        endcase
    end

    // Datapath: counters, low-byte holding register, write strobe
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            addr_cnt    <= '0;
            word_cnt    <= '0;
            lo_byte     <= '0;
            o_cfg_addr  <= '0;
            o_cfg_data  <= '0;
            o_cfg_wr_en <= 1'b0;
        end else begin
            o_cfg_wr_en <= 1'b0;
            if (accept) begin
                case (state_q)
                    S_HDR: begin
                        // Only the low ADDR_W bits address a register.
                        addr_cnt <= i_byte[ADDR_W-1:0];
                        word_cnt <= i_byte[7:4];
                    end
                    S_LO: lo_byte <= i_byte;
                    S_HI: begin
                        o_cfg_addr  <= addr_cnt;
                        o_cfg_data  <= {i_byte, lo_byte};
                        o_cfg_wr_en <= 1'b1;
                        // Natural wrap of an ADDR_W counter is modulo NUM_REG.
                        addr_cnt    <= addr_cnt + ADDR_W'(1);
                        word_cnt    <= word_cnt - 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef NN_CFG_LOADER_CHKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            csum  <= '0;
            o_err <= 1'b0;
        end else if (accept) begin
            case (state_q)
                S_HDR: begin
                    csum  <= i_byte;
                    o_err <= 1'b0;
                end
                S_LO, S_HI: csum <= csum ^ i_byte;
                S_CHK: if (csum != i_byte) o_err <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign o_err = 1'b0;
`endif

    // NUM_REG is implied by ADDR_W; kept for interface documentation.
    localparam int NUM_REG_CHK = NUM_REG;

endmodule

// File: tb/tb_nn_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_nn_cfg_loader
//   Directed bench for nn_cfg_loader. Expected writes are pushed when the
//   high byte is driven and popped by a monitor when the strobe appears.
// ---------------------------------------------------------------------------
module tb_nn_cfg_loader;

    logic        i_clk;
    logic        i_rst_n;
    logic [7:0]  i_byte;
    logic        i_byte_vld;
    logic        o_byte_rdy;
    logic [1:0]  o_cfg_addr;
    logic [15:0] o_cfg_data;
    logic        o_cfg_wr_en;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_dbg_state;

    nn_cfg_loader #(.NUM_REG(4), .ADDR_W(2), .DATA_W(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_byte      (i_byte),
        .i_byte_vld  (i_byte_vld),
        .o_byte_rdy  (o_byte_rdy),
        .o_cfg_addr  (o_cfg_addr),
        .o_cfg_data  (o_cfg_data),
        .o_cfg_wr_en (o_cfg_wr_en),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and cycle counter
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [17:0] exp_q[$];        // {addr, data}
    int          wr_times[$];
    logic [15:0] reg_obs [4];
    int          last_wr_cyc = -10;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample away from the active edge
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_cfg_wr_en === 1'b1) begin
            wr_times.push_back(cyc);
            last_wr_cyc = cyc;
            reg_obs[o_cfg_addr] = o_cfg_data;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {14'd0, o_cfg_addr, o_cfg_data}, 32'hFFFF_FFFF);
            end else begin
                chk("write", {14'd0, o_cfg_addr, o_cfg_data}, {14'd0, exp_q.pop_front()});
            end
        end
        if (i_rst_n === 1'b1 && o_done === 1'b1) begin
            done_cnt++;
`ifndef NN_CFG_LOADER_CHKSUM_EN
            chk("done_latency", cyc - last_wr_cyc, 1);
`endif
        end
    end

    // Driver tasks: called at #1 after a rising edge; valid left high.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_byte     = b;
        i_byte_vld = 1'b1;
        while (o_byte_rdy !== 1'b1 && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n >= 50) chk("rdy_timeout", n, 0);
        @(posedge i_clk); #1;
    endtask

    task automatic idle(input int n);
        i_byte_vld = 1'b0;
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic send_word(input logic [1:0] a, input logic [15:0] w, input int gap);
        send_byte(w[7:0]);
        if (gap > 0) begin
            int wr_before = wr_times.size();
            idle(gap);
            chk("gap_busy", o_busy, 1);
            chk("gap_no_write", wr_times.size(), wr_before);
        end
        exp_q.push_back({a, w});
        send_byte(w[15:8]);
    endtask

    // Sends header then words; gap cycles inserted inside word gap_idx.
    task automatic send_pkt(input logic [7:0] hdr, input logic [15:0] base, input logic [15:0] step,
                            input int gap_idx, input int gap);
        logic [1:0] a;
        int         nw;
        a  = hdr[1:0];
        nw = int'(hdr[7:4]) + 1;
        send_byte(hdr);
        for (int i = 0; i < nw; i++) begin
            send_word(a, base + step * 16'(i), (i == gap_idx) ? gap : 0);
            a = a + 2'd1;
        end
        exp_done++;
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_byte     = 8'h00;
        i_byte_vld = 1'b0;
        for (int i = 0; i < 4; i++) reg_obs[i] = '0;
        repeat (3) @(posedge i_clk);
        #1;

        // Reset values
        chk("rst_state", o_dbg_state, 0);
        chk("rst_rdy", o_byte_rdy, 1);
        chk("rst_outs", {o_cfg_wr_en, o_busy, o_done, o_err}, 4'b0000);
        chk("rst_addr_data", {o_cfg_addr, o_cfg_data}, 18'h0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // 1 word to addr 0
        send_byte(8'h00);
        chk("busy_after_hdr", o_busy, 1);
        exp_q.push_back({2'd0, 16'h1234});
        send_byte(8'h34);
        send_byte(8'h12);
        exp_done++;
        idle(4);
        chk("t1_busy_low", o_busy, 0);
        chk("t1_data_hold", {o_cfg_addr, o_cfg_data}, {2'd0, 16'h1234});

        // 4 words from addr 2, continuous valid, strobes 2 cycles apart
        wr_times.delete();
        send_byte(8'h32);
        send_word(2'd2, 16'hAAAA, 0);
        send_word(2'd3, 16'hBBBB, 0);
        send_word(2'd0, 16'hCCCC, 0);
        send_word(2'd1, 16'hDDDD, 0);
        exp_done++;
        idle(4);
        chk("t2_wr_count", wr_times.size(), 4);
        if (wr_times.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("t2_spacing", wr_times[i] - wr_times[i-1], 2);
        end

        // Same packet with a 5-cycle gap inside word index 1
        wr_times.delete();
        send_pkt(8'h32, 16'hAAAA, 16'h1111, 1, 5);
        idle(4);
        chk("t3_wr_count", wr_times.size(), 4);
        chk("t3_busy_low", o_busy, 0);

        // Reset during HI of word 0 of a 3-word packet
        send_byte(8'h22);
        send_byte(8'h55);
        chk("t4_in_hi", o_dbg_state, 2);
        i_rst_n    = 1'b0;
        i_byte     = 8'h66;
        i_byte_vld = 1'b1;
        @(posedge i_clk); #1;
        chk("t4_rst_state", o_dbg_state, 0);
        chk("t4_rst_outs", {o_byte_rdy, o_cfg_wr_en, o_busy, o_done, o_err}, 5'b10000);
        chk("t4_rst_addr_data", {o_cfg_addr, o_cfg_data}, 18'h0);
        i_rst_n    = 1'b1;
        i_byte_vld = 1'b0;
        idle(2);
        send_pkt(8'h01, 16'h0F0F, 16'h0, -1, 0);
        idle(4);
        chk("t4_after_rst", {o_cfg_addr, o_cfg_data}, {2'd1, 16'h0F0F});

`ifdef NN_CFG_LOADER_CHKSUM_EN
        // Good checksum
        exp_q.push_back({2'd1, 16'h1234});
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'h27);
        exp_done++;
        idle(3);
        chk("chk_good_err", o_err, 0);
        // Bad checksum: sticky until next header
        exp_q.push_back({2'd1, 16'h1234});
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12); send_byte(8'h00);
        exp_done++;
        idle(5);
        chk("chk_bad_err", o_err, 1);
        exp_q.push_back({2'd0, 16'h0000});
        send_byte(8'h00);
        chk("chk_err_cleared", o_err, 0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        exp_done++;
        idle(4);
        chk("chk_err_after_good", o_err, 0);
`else
        idle(2);
        chk("err_tied_low", o_err, 0);
`endif

        // Max packet: 16 words from addr 0, data = index
        wr_times.delete();
        send_pkt(8'hF0, 16'd0, 16'd1, -1, 0);
        idle(5);
        chk("max_wr_count", wr_times.size(), 16);
        for (int i = 0; i < 4; i++) chk("max_reg", reg_obs[i], 32'(12 + i));

        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, exp_done);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
